// File: rtl/hdr_pkg.sv
// Shared definitions for the header-checking stream stages: length width, FSM states, byte popcount.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package hdr_pkg;

  // Width of the header length field and of every byte counter derived from it.
  localparam int HDR_LEN_W = 16;

  // Widest tkeep the popcount helper accepts; narrower keeps are zero-extended by the caller.
  localparam int POPCNT_MAX_W = 128;

  // Header/payload tracking states.
  typedef enum logic {
    S_HEADER  = 1'b0,
    S_PAYLOAD = 1'b1
  } hdr_state_e;

  // Number of set byte enables. Non-contiguous keeps are fine: only the count matters.
  function automatic logic [HDR_LEN_W-1:0] popcount(input logic [POPCNT_MAX_W-1:0] bits);
    logic [HDR_LEN_W-1:0] cnt;
    cnt = '0;
    for (int i = 0; i < POPCNT_MAX_W; i++) begin
      cnt = cnt + HDR_LEN_W'(bits[i]);
    end
    return cnt;
  endfunction

endpackage

// File: rtl/axis_pipe_reg.sv
// Single-stage AXI-Stream register (data, keep, last, valid), reusable between stream stages.
// Latency: 1 cycle from input acceptance to output valid.
// Backpressure: in_tready_o = !out_tvalid_o | out_tready_i, full throughput, output held while stalled.
module axis_pipe_reg #(
  parameter int DW = 128,
  parameter int KW = DW / 8
) (
  input  logic          clk,
  input  logic          resetn,
  input  logic [DW-1:0] in_tdata_i,
  input  logic [KW-1:0] in_tkeep_i,
  input  logic          in_tlast_i,
  input  logic          in_tvalid_i,
  output logic          in_tready_o,
  output logic [DW-1:0] out_tdata_o,
  output logic [KW-1:0] out_tkeep_o,
  output logic          out_tlast_o,
  output logic          out_tvalid_o,
  input  logic          out_tready_i
);

  logic [DW-1:0] tdata_q, tdata_d;
  logic [KW-1:0] tkeep_q, tkeep_d;
  logic          tlast_q, tlast_d;
  logic          tvalid_q, tvalid_d;
  logic          load;

  // The register can take a new beat whenever it is empty or its current beat leaves this cycle.
  assign in_tready_o = !tvalid_q || out_tready_i;
  assign load        = in_tready_o && in_tvalid_i;

  // Next state: refill on an accepted beat, drain when the consumer takes the beat, else hold.
  always_comb begin
    tdata_d  = tdata_q;
    tkeep_d  = tkeep_q;
    tlast_d  = tlast_q;
    tvalid_d = tvalid_q;
    if (in_tready_o) begin
      tvalid_d = in_tvalid_i;
    end
    if (load) begin
      tdata_d = in_tdata_i;
      tkeep_d = in_tkeep_i;
      tlast_d = in_tlast_i;
    end
  end

  // Output register; reset clears the whole beat so nothing stale survives a mid-packet reset.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      tdata_q  <= '0;
      tkeep_q  <= '0;
      tlast_q  <= 1'b0;
      tvalid_q <= 1'b0;
    end else begin
      tdata_q  <= tdata_d;
      tkeep_q  <= tkeep_d;
      tlast_q  <= tlast_d;
      tvalid_q <= tvalid_d;
    end
  end

  assign out_tdata_o  = tdata_q;
  assign out_tkeep_o  = tkeep_q;
  assign out_tlast_o  = tlast_q;
  assign out_tvalid_o = tvalid_q;

endmodule

// File: rtl/check_header.sv
// Strips the one-beat length header, forwards payload, checks declared vs counted bytes. Optional err_count: CHECK_HEADER_ERRCNT_EN.
// Latency: 1 cycle input acceptance to axis_out_tvalid; stat_valid/stat_hdr_err 1 cycle after the qualifying beat.
// Backpressure: axis_in_tready = !axis_out_tvalid | axis_out_tready; header beats consume an input slot with no output.
module check_header
  import hdr_pkg::*;
#(
  parameter int DW = 128,
  parameter int LW = HDR_LEN_W
) (
  input  logic            clk,
  input  logic            resetn,
  input  logic [DW-1:0]   axis_in_tdata,
  input  logic [DW/8-1:0] axis_in_tkeep,
  input  logic            axis_in_tlast,
  input  logic            axis_in_tvalid,
  output logic            axis_in_tready,
  output logic [DW-1:0]   axis_out_tdata,
  output logic [DW/8-1:0] axis_out_tkeep,
  output logic            axis_out_tlast,
  output logic            axis_out_tvalid,
  input  logic            axis_out_tready,
  output logic            stat_valid,
  output logic            stat_len_ok,
  output logic [LW-1:0]   stat_len,
  output logic            stat_hdr_err,
  output logic [15:0]     err_count,
  input  logic            err_clr
);

  localparam int KW = DW / 8;

  hdr_state_e    state_q;
  logic [LW-1:0] declared_len_q;
  logic [LW-1:0] byte_cnt_q;
  logic          stat_valid_q;
  logic          stat_len_ok_q;
  logic [LW-1:0] stat_len_q;
  logic          stat_hdr_err_q;

  logic          in_rdy;
  logic          accept;
  logic          pipe_vld;
  logic [LW-1:0] beat_bytes;
  logic [LW-1:0] len_final;
  logic          hdr_bad;
  logic          len_bad;
  logic          err_inc;

  // Header beats are swallowed here: only payload beats are offered to the output register.
  assign accept   = axis_in_tvalid && in_rdy;
  assign pipe_vld = axis_in_tvalid && (state_q == S_PAYLOAD);

  // Byte accounting is LW-bit unsigned; wrap-around is intentionally compared as-is.
  assign beat_bytes = LW'(popcount(POPCNT_MAX_W'(axis_in_tkeep)));
  assign len_final  = byte_cnt_q + beat_bytes;

  // Error events, evaluated on the accepting edge.
  assign hdr_bad = accept && (state_q == S_HEADER) && axis_in_tlast;
  assign len_bad = accept && (state_q == S_PAYLOAD) && axis_in_tlast && (len_final != declared_len_q);
  assign err_inc = hdr_bad || len_bad;

  axis_pipe_reg #(
    .DW (DW),
    .KW (KW)
  ) u_out_reg (
    .clk          (clk),
    .resetn       (resetn),
    .in_tdata_i   (axis_in_tdata),
    .in_tkeep_i   (axis_in_tkeep),
    .in_tlast_i   (axis_in_tlast),
    .in_tvalid_i  (pipe_vld),
    .in_tready_o  (in_rdy),
    .out_tdata_o  (axis_out_tdata),
    .out_tkeep_o  (axis_out_tkeep),
    .out_tlast_o  (axis_out_tlast),
    .out_tvalid_o (axis_out_tvalid),
    .out_tready_i (axis_out_tready)
  );

  assign axis_in_tready = in_rdy;

  // Header/payload FSM with registered length tracking and status outputs.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q        <= S_HEADER;
      declared_len_q <= '0;
      byte_cnt_q     <= '0;
      stat_valid_q   <= 1'b0;
      stat_len_ok_q  <= 1'b0;
      stat_len_q     <= '0;
      stat_hdr_err_q <= 1'b0;
    end else begin
      stat_valid_q   <= 1'b0;
      stat_hdr_err_q <= 1'b0;
      case (state_q)
        S_HEADER: begin
          if (accept) begin
            if (axis_in_tlast) begin
              // A header that also closes the packet carries no payload: flag it and wait for the next header.
              stat_hdr_err_q <= 1'b1;
            end else begin
              declared_len_q <= axis_in_tdata[LW-1:0];
              byte_cnt_q     <= '0;
              state_q        <= S_PAYLOAD;
            end
          end
        end
        S_PAYLOAD: begin
          if (accept) begin
            byte_cnt_q <= len_final;
            if (axis_in_tlast) begin
              stat_valid_q  <= 1'b1;
              stat_len_q    <= len_final;
              stat_len_ok_q <= (len_final == declared_len_q);
              state_q       <= S_HEADER;
            end
          end
        end
        default: state_q <= S_HEADER;
      endcase
    end
  end

  assign stat_valid   = stat_valid_q;
  assign stat_len_ok  = stat_len_ok_q;
  assign stat_len     = stat_len_q;
  assign stat_hdr_err = stat_hdr_err_q;

`ifdef CHECK_HEADER_ERRCNT_EN
  logic [15:0] err_count_q;

  // Saturating error counter; a clear in the same cycle as an error wins.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      err_count_q <= '0;
    end else if (err_clr) begin
      err_count_q <= '0;
    end else if (err_inc && (err_count_q != 16'hFFFF)) begin
      err_count_q <= err_count_q + 16'd1;
    end
  end

  assign err_count = err_count_q;
`else
  // Counter not built: register map reads zero and the clear has no effect.
  logic unused_errcnt;
  assign unused_errcnt = err_clr ^ err_inc;
  assign err_count     = '0;
`endif

endmodule

// File: tb/tb_check_header.sv
// Directed bench for check_header: framing, length check, header error, backpressure, mid-packet reset.
// Latency: outputs sampled on the falling edge, inputs driven 1 time unit after the rising edge.
// Backpressure: random axis_out_tready during the back-to-back packet scenario.
module tb_check_header;

  localparam int DW = 128;
  localparam int KW = DW / 8;
  localparam int LW = 16;
`ifdef CHECK_HEADER_ERRCNT_EN
  localparam bit ERRCNT_ON = 1'b1;
`else
  localparam bit ERRCNT_ON = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          resetn;
  logic [DW-1:0] axis_in_tdata;
  logic [KW-1:0] axis_in_tkeep;
  logic          axis_in_tlast;
  logic          axis_in_tvalid;
  logic          axis_in_tready;
  logic [DW-1:0] axis_out_tdata;
  logic [KW-1:0] axis_out_tkeep;
  logic          axis_out_tlast;
  logic          axis_out_tvalid;
  logic          axis_out_tready;
  logic          stat_valid;
  logic          stat_len_ok;
  logic [LW-1:0] stat_len;
  logic          stat_hdr_err;
  logic [15:0]   err_count;
  logic          err_clr;

  int checks = 0;
  int errors = 0;

  // Monitor records
  logic [DW-1:0] cap_dat[$];
  logic [KW-1:0] cap_keep[$];
  logic          cap_last[$];
  logic [LW-1:0] st_len[$];
  logic          st_ok[$];
  int            hdr_err_cnt = 0;
  int            stall_viol  = 0;
  int            stat_align_err = 0;
  bit            bp_en = 1'b0;

  logic          prev_stall = 1'b0;
  logic [DW-1:0] prev_d;
  logic [KW-1:0] prev_k;
  logic          prev_l;

  always #5 clk = ~clk;

  check_header #(.DW(DW), .LW(LW)) dut (
    .clk             (clk),
    .resetn          (resetn),
    .axis_in_tdata   (axis_in_tdata),
    .axis_in_tkeep   (axis_in_tkeep),
    .axis_in_tlast   (axis_in_tlast),
    .axis_in_tvalid  (axis_in_tvalid),
    .axis_in_tready  (axis_in_tready),
    .axis_out_tdata  (axis_out_tdata),
    .axis_out_tkeep  (axis_out_tkeep),
    .axis_out_tlast  (axis_out_tlast),
    .axis_out_tvalid (axis_out_tvalid),
    .axis_out_tready (axis_out_tready),
    .stat_valid      (stat_valid),
    .stat_len_ok     (stat_len_ok),
    .stat_len        (stat_len),
    .stat_hdr_err    (stat_hdr_err),
    .err_count       (err_count),
    .err_clr         (err_clr)
  );

  // Random consumer readiness, changed just after each rising edge.
  always @(posedge clk) begin
    if (bp_en) begin
      #1;
      axis_out_tready = 1'($urandom_range(0, 1));
    end
  end

  // Falling-edge monitor: captures transfers and status, tracks stall stability.
  always @(negedge clk) begin
    if (!resetn) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall && (!axis_out_tvalid || axis_out_tdata !== prev_d ||
                         axis_out_tkeep !== prev_k || axis_out_tlast !== prev_l))
        stall_viol++;
      prev_stall = axis_out_tvalid && !axis_out_tready;
      prev_d = axis_out_tdata;
      prev_k = axis_out_tkeep;
      prev_l = axis_out_tlast;
      if (axis_out_tvalid && axis_out_tready) begin
        cap_dat.push_back(axis_out_tdata);
        cap_keep.push_back(axis_out_tkeep);
        cap_last.push_back(axis_out_tlast);
      end
      if (stat_valid) begin
        st_len.push_back(stat_len);
        st_ok.push_back(stat_len_ok);
        if (!(axis_out_tvalid && axis_out_tlast)) stat_align_err++;
      end
      if (stat_hdr_err) hdr_err_cnt++;
    end
  end

  task automatic clear_records();
    cap_dat.delete();
    cap_keep.delete();
    cap_last.delete();
    st_len.delete();
    st_ok.delete();
    hdr_err_cnt = 0;
  endtask

  // Present one beat and hold it until the DUT accepts it (bounded).
  task automatic send_beat(input logic [DW-1:0] d, input logic [KW-1:0] k, input logic l);
    bit done;
    int guard;
    axis_in_tdata  = d;
    axis_in_tkeep  = k;
    axis_in_tlast  = l;
    axis_in_tvalid = 1'b1;
    done  = 1'b0;
    guard = 0;
    while (!done) begin
      @(negedge clk);
      if (axis_in_tready) done = 1'b1;
      @(posedge clk);
      #1;
      guard++;
      if (!done && guard > 200) begin
        checks++;
        errors++;
        $display("FAIL send_timeout: tready=%0b after %0d cycles, required 1", axis_in_tready, guard);
        done = 1'b1;
      end
    end
    axis_in_tvalid = 1'b0;
  endtask

  task automatic send_header(input logic [15:0] len);
    logic [DW-1:0] d;
    d = '0;
    d[15:0] = len;
    d[DW-1:DW-32] = 32'hDEAD_BEEF;
    send_beat(d, {KW{1'b1}}, 1'b0);
  endtask

  task automatic drain();
    repeat (4) @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    resetn = 1'b1;
    #1 resetn = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if ({axis_out_tvalid, axis_out_tlast, stat_valid, stat_len_ok, stat_hdr_err} !== 5'b0 ||
        axis_out_tdata !== '0 || axis_out_tkeep !== '0 || stat_len !== '0 || err_count !== 16'd0) begin
      errors++;
      $display("FAIL reset_outputs: tvalid=%0b tlast=%0b data=%h keep=%h sv=%0b ok=%0b len=%0d he=%0b ec=%0d, required all 0",
               axis_out_tvalid, axis_out_tlast, axis_out_tdata, axis_out_tkeep, stat_valid, stat_len_ok,
               stat_len, stat_hdr_err, err_count);
    end
    checks++;
    if (axis_in_tready !== 1'b1) begin
      errors++;
      $display("FAIL reset_tready: got %0b required 1", axis_in_tready);
    end
    @(posedge clk);
    #1 resetn = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_full_packet();
    logic [DW-1:0] exp_d [3];
    clear_records();
    for (int i = 0; i < 3; i++) exp_d[i] = {4{32'hA000_0000 + 32'(i)}};
    send_header(16'h0030);
    for (int i = 0; i < 3; i++) send_beat(exp_d[i], 16'hFFFF, (i == 2));
    drain();
    checks++;
    if (cap_dat.size() !== 3) begin
      errors++;
      $display("FAIL full_beats: got %0d beats required 3", cap_dat.size());
    end else begin
      for (int i = 0; i < 3; i++) begin
        checks++;
        if (cap_dat[i] !== exp_d[i] || cap_last[i] !== (i == 2) || cap_keep[i] !== 16'hFFFF) begin
          errors++;
          $display("FAIL full_beat%0d: data=%h last=%0b keep=%h required data=%h last=%0b keep=ffff",
                   i, cap_dat[i], cap_last[i], cap_keep[i], exp_d[i], (i == 2));
        end
      end
    end
    checks++;
    if (st_len.size() !== 1 || st_len[0] !== 16'd48 || st_ok[0] !== 1'b1) begin
      errors++;
      $display("FAIL full_stat: pulses=%0d len=%0d ok=%0b required 1 pulse len=48 ok=1",
               st_len.size(), (st_len.size() > 0) ? st_len[0] : 16'hFFFF, (st_ok.size() > 0) ? st_ok[0] : 1'bx);
    end
    checks++;
    if (err_count !== 16'd0) begin
      errors++;
      $display("FAIL full_errcnt: got %0d required 0", err_count);
    end
  endtask

  task automatic test_partial_keep();
    clear_records();
    send_header(16'h0014);
    send_beat({4{32'hB000_0001}}, 16'hFFFF, 1'b0);
    send_beat({4{32'hB000_0002}}, 16'h000F, 1'b1);
    drain();
    checks++;
    if (st_len.size() !== 1 || st_len[0] !== 16'd20 || st_ok[0] !== 1'b1) begin
      errors++;
      $display("FAIL partial_stat: pulses=%0d len=%0d required 1 pulse len=20 ok=1",
               st_len.size(), (st_len.size() > 0) ? st_len[0] : 16'hFFFF);
    end
    checks++;
    if (cap_keep.size() !== 2 || cap_keep[1] !== 16'h000F || cap_last[1] !== 1'b1) begin
      errors++;
      $display("FAIL partial_beats: count=%0d required 2 with keep 000f last 1", cap_keep.size());
    end
  endtask

  task automatic test_mismatch();
    logic [15:0] exp_ec;
    exp_ec = ERRCNT_ON ? 16'd1 : 16'd0;
    clear_records();
    send_header(16'h0020);
    send_beat({4{32'hC000_0001}}, 16'hFFFF, 1'b1);
    drain();
    checks++;
    if (st_len.size() !== 1 || st_len[0] !== 16'd16 || st_ok[0] !== 1'b0) begin
      errors++;
      $display("FAIL mismatch_stat: pulses=%0d len=%0d required 1 pulse len=16 ok=0",
               st_len.size(), (st_len.size() > 0) ? st_len[0] : 16'hFFFF);
    end
    checks++;
    if (cap_dat.size() !== 1 || cap_dat[0] !== {4{32'hC000_0001}} || cap_last[0] !== 1'b1) begin
      errors++;
      $display("FAIL mismatch_fwd: beats=%0d required 1 beat c0000001 with tlast", cap_dat.size());
    end
    checks++;
    if (err_count !== exp_ec) begin
      errors++;
      $display("FAIL mismatch_errcnt: got %0d required %0d", err_count, exp_ec);
    end
  endtask

  task automatic test_hdr_err();
    logic [15:0] exp_ec;
    exp_ec = ERRCNT_ON ? 16'd1 : 16'd0;
    err_clr = 1'b1;
    @(posedge clk);
    #1 err_clr = 1'b0;
    checks++;
    if (err_count !== 16'd0) begin
      errors++;
      $display("FAIL errclr: got %0d required 0", err_count);
    end
    clear_records();
    send_beat({4{32'hEEEE_0010}}, 16'hFFFF, 1'b1);
    send_header(16'h0010);
    send_beat({4{32'hD000_0001}}, 16'hFFFF, 1'b1);
    drain();
    checks++;
    if (hdr_err_cnt !== 1) begin
      errors++;
      $display("FAIL hdr_err_pulses: got %0d required 1", hdr_err_cnt);
    end
    checks++;
    if (cap_dat.size() !== 1 || cap_dat[0] !== {4{32'hD000_0001}}) begin
      errors++;
      $display("FAIL hdr_err_fwd: beats=%0d required 1 beat d0000001", cap_dat.size());
    end
    checks++;
    if (st_ok.size() !== 1 || st_ok[0] !== 1'b1 || st_len[0] !== 16'd16) begin
      errors++;
      $display("FAIL hdr_err_stat: pulses=%0d required 1 pulse ok=1 len=16", st_ok.size());
    end
    checks++;
    if (err_count !== exp_ec) begin
      errors++;
      $display("FAIL hdr_err_errcnt: got %0d required %0d", err_count, exp_ec);
    end
  endtask

  task automatic test_back_to_back();
    logic [DW-1:0] exp_dat[$];
    logic [KW-1:0] exp_keep[$];
    logic          exp_last[$];
    int            nbeats;
    int            bad;
    int            guard;
    int            nok;
    logic [KW-1:0] lk;
    logic [15:0]   dlen;
    logic [DW-1:0] d;
    clear_records();
    stall_viol = 0;
    stat_align_err = 0;
    bp_en = 1'b1;
    for (int p = 0; p < 100; p++) begin
      nbeats = 1 + (p % 4);
      lk     = 16'hFFFF >> (p % 16);
      dlen   = 16'((nbeats - 1) * 16 + (16 - (p % 16)));
      send_header(dlen);
      for (int b = 0; b < nbeats; b++) begin
        d = {32'(p), 32'(b), 32'h5A5A_0000 + 32'(p * 8 + b), 32'hF00D_CAFE};
        exp_dat.push_back(d);
        exp_keep.push_back((b == nbeats - 1) ? lk : 16'hFFFF);
        exp_last.push_back(b == nbeats - 1);
        send_beat(d, (b == nbeats - 1) ? lk : 16'hFFFF, (b == nbeats - 1));
      end
    end
    guard = 0;
    while (axis_out_tvalid !== 1'b0 && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    checks++;
    if (guard >= 100) begin
      errors++;
      $display("FAIL b2b_drain: tvalid=%0b after %0d cycles, required 0", axis_out_tvalid, guard);
    end
    bp_en = 1'b0;
    @(posedge clk);
    #1 axis_out_tready = 1'b1;
    drain();
    checks++;
    if (cap_dat.size() !== exp_dat.size()) begin
      errors++;
      $display("FAIL b2b_count: got %0d beats required %0d", cap_dat.size(), exp_dat.size());
    end
    bad = 0;
    for (int i = 0; i < exp_dat.size() && i < cap_dat.size(); i++)
      if (cap_dat[i] !== exp_dat[i] || cap_keep[i] !== exp_keep[i] || cap_last[i] !== exp_last[i]) bad++;
    checks++;
    if (bad !== 0) begin
      errors++;
      $display("FAIL b2b_data: %0d beats differ, required 0", bad);
    end
    nok = 0;
    foreach (st_ok[i]) if (st_ok[i] === 1'b1) nok++;
    checks++;
    if (st_ok.size() !== 100 || nok !== 100) begin
      errors++;
      $display("FAIL b2b_stat: pulses=%0d ok=%0d required 100 and 100", st_ok.size(), nok);
    end
    checks++;
    if (stall_viol !== 0) begin
      errors++;
      $display("FAIL b2b_stall: %0d unstable stall cycles, required 0", stall_viol);
    end
    checks++;
    if (stat_align_err !== 0) begin
      errors++;
      $display("FAIL b2b_stat_align: %0d stat pulses without last beat on output, required 0", stat_align_err);
    end
  endtask

  task automatic test_reset_mid();
    axis_out_tready = 1'b0;
    send_header(16'h0020);
    send_beat({4{32'h7777_0001}}, 16'hFFFF, 1'b0);
    resetn = 1'b0;
    @(negedge clk);
    checks++;
    if (axis_out_tvalid !== 1'b0 || axis_out_tdata !== '0 || axis_out_tkeep !== '0 ||
        axis_out_tlast !== 1'b0 || stat_valid !== 1'b0 || stat_len !== '0 || stat_len_ok !== 1'b0 ||
        stat_hdr_err !== 1'b0 || err_count !== 16'd0) begin
      errors++;
      $display("FAIL midreset_outputs: tvalid=%0b data=%h keep=%h len=%0d ec=%0d, required all 0",
               axis_out_tvalid, axis_out_tdata, axis_out_tkeep, stat_len, err_count);
    end
    @(posedge clk);
    #1 resetn = 1'b1;
    axis_out_tready = 1'b1;
    clear_records();
    send_header(16'h0010);
    send_beat({4{32'h8888_0001}}, 16'hFFFF, 1'b1);
    drain();
    checks++;
    if (st_ok.size() !== 1 || st_ok[0] !== 1'b1 || st_len[0] !== 16'd16) begin
      errors++;
      $display("FAIL midreset_stat: pulses=%0d required 1 pulse ok=1 len=16", st_ok.size());
    end
    checks++;
    if (cap_dat.size() !== 1 || cap_dat[0] !== {4{32'h8888_0001}} || cap_last[0] !== 1'b1) begin
      errors++;
      $display("FAIL midreset_fwd: beats=%0d required 1 beat 88880001 with tlast", cap_dat.size());
    end
  endtask

  initial begin
    axis_in_tdata   = '0;
    axis_in_tkeep   = '0;
    axis_in_tlast   = 1'b0;
    axis_in_tvalid  = 1'b0;
    axis_out_tready = 1'b1;
    err_clr         = 1'b0;
    test_reset();
    test_full_packet();
    test_partial_keep();
    test_mismatch();
    test_hdr_err();
    test_back_to_back();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/check_header.md
# check_header

Downstream neighbour of the header-insertion stage. Consumes an AXI-Stream in which every packet is preceded by a one-beat header carrying the packet byte length in `tdata[15:0]`. Removes the header, forwards the payload unchanged through a one-stage output register, and compares the declared length with the counted `tkeep` bytes. Reports a per-packet status pulse and an optional error counter for the board-level register map.

## Interface
- `DW`, 128: stream data width in bits. Must be a multiple of 8, and at least 16.
- `LW`, 16: header length field width, taken from `tdata[LW-1:0]` of the header beat.

Ports:
- `clk` in 1: single clock.
- `resetn` in 1: reset, asynchronous and active-low.
- `axis_in_tdata` in DW: header and payload data.
- `axis_in_tkeep` in DW/8: byte enables. Ignored on header beats.
- `axis_in_tlast` in 1: last payload beat.
- `axis_in_tvalid` in 1.
- `axis_in_tready` out 1.
- `axis_out_tdata` out DW: payload only.
- `axis_out_tkeep` out DW/8.
- `axis_out_tlast` out 1.
- `axis_out_tvalid` out 1.
- `axis_out_tready` in 1.
- `stat_valid` out 1: one-cycle pulse per packet.
- `stat_len_ok` out 1: qualified by `stat_valid`. Set when the declared length equals the counted length.
- `stat_len` out LW: counted byte length, qualified by `stat_valid`.
- `stat_hdr_err` out 1: one-cycle pulse for a header beat with `tlast`=1.
- `err_count` out 16: length-mismatch and header-error count.
- `err_clr` in 1: synchronous clear of `err_count`.

## Operation
- The FSM has two states:
  - `S_HEADER` (reset state).
  - `S_PAYLOAD`.
- In `S_HEADER`:
  - An accepted beat latches `declared_len <= tdata[LW-1:0]` and clears `byte_cnt`.
  - The beat is not forwarded.
  - The FSM moves to `S_PAYLOAD`.
- If the header beat has `tlast`=1:
  - `stat_hdr_err` pulses.
  - The error count increments.
  - The FSM stays in `S_HEADER`.
  - Nothing is forwarded and no `stat_valid` is generated.
- In `S_PAYLOAD`:
  - Each accepted beat is written to the output register.
  - `byte_cnt <= byte_cnt + popcount(tkeep)`, modulo 2^LW.
- When the accepted payload beat has `tlast`=1:
  - Final length = `byte_cnt + popcount(tkeep)`.
  - This value is compared with `declared_len` and the status is registered.
  - The FSM returns to `S_HEADER`.
- On a mismatch, `stat_len_ok`=0 and the error count increments. Payload is always forwarded intact: the block neither truncates nor pads.
- Length arithmetic is LW bits and unsigned. Wrap-around is compared as-is, so a 65 537-byte packet declaring length 1 reports ok. This is accepted behaviour.
- `tkeep` is not required to be contiguous; only the popcount matters.

## Timing
- Reset values (asynchronous):
  - All `axis_out_*` = 0.
  - `stat_*` = 0.
  - `err_count` = 0.
  - FSM = `S_HEADER`.
  - `byte_cnt` = 0 and `declared_len` = 0.
- Reset asserted mid-packet discards the output register contents. The next accepted beat after release is treated as a header.
- `axis_in_tready = !axis_out_tvalid | axis_out_tready`. It is registered-path free and gives full throughput.
- Header beats are accepted under the same rule and consume one input cycle with no output beat.
- Latency: input acceptance to `axis_out_tvalid` is 1 cycle.
- `stat_valid` and `stat_hdr_err` are asserted the cycle after the qualifying input acceptance. `stat_valid` therefore coincides with the first cycle the last beat is presented on the output.
- Output held while stalled: `axis_out_*` are stable while `tvalid` is 1 and `tready` is 0.
- `err_clr` coincident with an increment: the clear wins and the count becomes 0.
- `err_count` saturates at 0xFFFF.

## Configuration
- `CHECK_HEADER_ERRCNT_EN` defined:
  - The 16-bit saturating `err_count` register and the `err_clr` logic are built.
- Not defined:
  - `err_count` is tied to 0 and `err_clr` is ignored.
  - Ports still exist.
  - `stat_*` behaviour is unchanged.

## Structure
- Shared package `hdr_pkg` holds:
  - `HDR_LEN_W` = 16.
  - The FSM state typedef (`S_HEADER`, `S_PAYLOAD`).
  - The `popcount` function over DW/8 bits.
- One sub-module, `axis_pipe_reg`, is the single-stage AXIS register (data, keep, last, valid, with the ready rule above). It is reusable across the stream stages.

## Test plan
- Header 0x0030, then 3 full beats (`tkeep`=0xFFFF), last on beat 3:
  - Exactly 3 output beats, `tlast` on the third.
  - `stat_valid`=1, `stat_len_ok`=1, `stat_len`=48.
  - `err_count`=0.
- Header 0x0014, then beats with `tkeep`=0xFFFF and 0x000F:
  - `stat_len`=20, ok=1.
- Header 0x0020 with payload of 1 full beat:
  - `stat_len`=16, ok=0, `err_count`=1.
  - Payload still forwarded with `tlast`.
- Header beat with `tlast`=1, followed by header 0x0010 and 1 full beat:
  - `stat_hdr_err` pulses once and nothing is forwarded for the bad header.
  - The second packet reports ok and `err_count`=1.
- Random `axis_out_tready` backpressure (about 50 %) over 100 back-to-back packets:
  - No data loss or duplication.
  - Output stable during stalls.
  - 100 `stat_valid` pulses.
- `resetn` dropped mid-payload, then released and sent header 0x0010 plus 1 full beat:
  - All outputs are 0 during reset.
  - The packet after reset reports ok.
